uart2fifo: RTL and testbench

- Receive-side counterpart of fifo2uart: collects a frame of data_len bytes from uart_rx and writes each byte into the downstream FIFO.
- Sits between uart_rx and the RX FIFO.
- Uses the same fs/fd start/done handshake as fifo2uart.
- Optional header-byte sync; inter-byte timeout aborts stalled frames.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart2fifo.sv | 179 +++++++++++++++++
 tb/tb_uart2fifo.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-controller state encoding, default sync byte,
// and the clock-cycles-per-bit helper used by all UART-side blocks.
package uart_pkg;

    // Frame controller states (shared with the transmit-side controller).
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_HEAD = 3'd1,
        RECV      = 3'd2,
        DONE      = 3'd3,
        ERR       = 3'd4
    } state_t;

    // Default frame sync byte.
    localparam logic [7:0] HEAD_BYTE_DEF = 8'h55;

    // System clock cycles per UART bit; clk_fre is in MHz.
    function automatic int cyc_per_bit(input int clk_fre, input int baud_rate);
        return (clk_fre * 1000000) / baud_rate;
    endfunction

endpackage

// File: rtl/uart2fifo.sv
// uart2fifo: collects a frame of data_len bytes from uart_rx and writes each
// byte into the downstream RX FIFO. Frame start/done use the fs/fd level
// handshake. An optional header byte synchronises the frame, and an
// inter-byte timeout aborts frames whose sender has stalled.
module uart2fifo
    import uart_pkg::*;
#(
    parameter int          CLK_FRE       = 50,
    parameter int          BAUD_RATE     = 115200,
    parameter int          TIMEOUT_BYTES = 4,
    parameter int          HEAD_EN       = 1,
    parameter logic [7:0]  HEAD_BYTE     = HEAD_BYTE_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fs,
    output logic       fd,
    input  logic [7:0] data_len,
    input  logic [7:0] uart_rxd,
    input  logic       uart_rxdv,
    output logic       uart_rxdr,
    input  logic       fifo_full,
    output logic       fifo_txen,
    output logic [7:0] fifo_txd,
    output logic [7:0] rx_cnt,
    output logic       err
);

    // Idle gap allowed between payload bytes, in system clock cycles.
    localparam int TIMEOUT_CYC = TIMEOUT_BYTES * 10 * cyc_per_bit(CLK_FRE, BAUD_RATE);
    localparam int TMO_W       = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

    // Registered state and datapath.
    state_t            state_reg, state_next;
    logic [7:0]        len_reg, len_next;
    logic [7:0]        rx_cnt_reg, rx_cnt_next;
    logic [TMO_W-1:0]  tmo_reg, tmo_next;
    logic [TMO_W-1:0]  tmo_inc;
    logic              txen_reg, txen_next;
    logic [7:0]        txd_reg, txd_next;
    logic              fd_reg;
    logic              err_reg;
    logic              rxdr_reg;

    logic              accept;
    logic              last_byte;

    // Handshake with uart_rx: a byte moves only when valid and ready coincide.
    assign accept    = uart_rxdv && uart_rxdr;
    assign tmo_inc   = tmo_reg + TMO_W'(1);
    assign last_byte = (rx_cnt_reg + 8'd1) == len_reg;

    // Next-state, byte counter, timeout counter and FIFO write generation.
    always_comb begin
        state_next  = state_reg;
        len_next    = len_reg;
        rx_cnt_next = rx_cnt_reg;
        tmo_next    = tmo_reg;
        txen_next   = 1'b0;
        txd_next    = txd_reg;

        case (state_reg)
            IDLE: begin
                // Stray bytes seen here are accepted by the ready and dropped.
                if (fs) begin
                    len_next    = data_len;
                    rx_cnt_next = 8'd0;
                    tmo_next    = '0;
                    if (data_len == 8'd0) begin
                        state_next = DONE;
                    end else if (HEAD_EN != 0) begin
                        state_next = WAIT_HEAD;
                    end else begin
                        state_next = RECV;
                    end
                end
            end

            WAIT_HEAD: begin
                // Hunt for the sync byte; anything else is discarded.
                // No timeout here: the link may legitimately be quiet.
                if (!fs) begin
                    state_next = IDLE;
                end else if (accept && (uart_rxd == HEAD_BYTE)) begin
                    tmo_next   = '0;
                    state_next = RECV;
                end
            end

            RECV: begin
                if (accept) begin
                    // An accepted byte is always written, even if fs has just
                    // dropped, so that nothing taken from uart_rx is lost.
                    txen_next   = 1'b1;
                    txd_next    = uart_rxd;
                    rx_cnt_next = rx_cnt_reg + 8'd1;
                    tmo_next    = '0;
                    if (!fs) begin
                        state_next = IDLE;
                    end else if (last_byte) begin
                        // Accept beats a simultaneous timeout expiry.
                        state_next = DONE;
                    end
                end else if (!fs) begin
                    state_next = IDLE;
                end else if (fifo_full) begin
                    // Back-pressure stall is not a link timeout: hold count.
                    tmo_next = tmo_reg;
                end else begin
                    tmo_next = tmo_inc;
                    if (tmo_inc == TMO_LAST) begin
                        state_next = ERR;
                    end
                end
            end

            DONE, ERR: begin
                // Stay until the controller drops fs for at least one cycle.
                if (!fs) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Frame datapath registers: latched length, byte count, timeout count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg    <= 8'd0;
            rx_cnt_reg <= 8'd0;
            tmo_reg    <= '0;
        end else begin
            len_reg    <= len_next;
            rx_cnt_reg <= rx_cnt_next;
            tmo_reg    <= tmo_next;
        end
    end

    // Registered outputs, decoded from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txen_reg <= 1'b0;
            txd_reg  <= 8'd0;
            fd_reg   <= 1'b0;
            err_reg  <= 1'b0;
            rxdr_reg <= 1'b0;
        end else begin
            txen_reg <= txen_next;
            txd_reg  <= txd_next;
            fd_reg   <= (state_next == DONE) || (state_next == ERR);
            err_reg  <= (state_next == ERR);
            rxdr_reg <= (state_next == IDLE) || (state_next == WAIT_HEAD);
        end
    end

    // In RECV the ready follows fifo_full directly so a full FIFO stops the
    // byte in the same cycle; elsewhere it is the registered value.
    assign uart_rxdr = (state_reg == RECV) ? ~fifo_full : rxdr_reg;
    assign fifo_txen = txen_reg;
    assign fifo_txd  = txd_reg;
    assign rx_cnt    = rx_cnt_reg;
    assign fd        = fd_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_uart2fifo.sv
// Directed testbench for uart2fifo: a scoreboard queue holds the payload
// bytes expected at the FIFO port and a monitor checks every write.
module tb_uart2fifo;

    localparam int TIMEOUT_CYC = 4 * 10 * (50 * 1000000 / 115200);

    logic       clk;
    logic       rst_n;
    logic       fs;
    logic       fd;
    logic [7:0] data_len;
    logic [7:0] uart_rxd;
    logic       uart_rxdv;
    logic       uart_rxdr;
    logic       fifo_full;
    logic       fifo_txen;
    logic [7:0] fifo_txd;
    logic [7:0] rx_cnt;
    logic       err;

    int         vectors     = 0;
    int         miscompares = 0;
    int         wr_count    = 0;
    int         cyc         = 0;
    int         acc_edge    = 0;
    logic [7:0] exp_q[$];

    uart2fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fs        (fs),
        .fd        (fd),
        .data_len  (data_len),
        .uart_rxd  (uart_rxd),
        .uart_rxdv (uart_rxdv),
        .uart_rxdr (uart_rxdr),
        .fifo_full (fifo_full),
        .fifo_txen (fifo_txen),
        .fifo_txd  (fifo_txd),
        .rx_cnt    (rx_cnt),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so latencies can be measured in cycles.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every FIFO write must match the next expected byte.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && fifo_txen === 1'b1) begin
            wr_count++;
            check("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("wr_data", 32'(fifo_txd), 32'(e));
                $display("write %0d: data %02h expected %02h", wr_count, fifo_txd, e);
            end
        end
    end

    // Present one byte, wait for ready, and hold valid through the accept edge.
    // Called and returns on a falling edge.
    task automatic send_byte(input logic [7:0] b, input bit expect_write);
        int n;
        if (expect_write) exp_q.push_back(b);
        uart_rxd  = b;
        uart_rxdv = 1'b1;
        #1;
        n = 0;
        while (uart_rxdr !== 1'b1 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) check("rxdr_wait_timeout", 32'(uart_rxdr), 32'd1);
        acc_edge = cyc + 1;
        @(posedge clk);
        @(negedge clk);
        uart_rxdv = 1'b0;
    endtask

    task automatic start_frame(input logic [7:0] len);
        data_len = len;
        fs       = 1'b1;
        @(negedge clk);
    endtask

    task automatic end_frame();
        fs = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int wr0;
        bit rdy_seen;
        bit err_seen;

        rst_n     = 1'b0;
        fs        = 1'b0;
        data_len  = 8'd0;
        uart_rxd  = 8'd0;
        uart_rxdv = 1'b0;
        fifo_full = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_fd",   32'(fd), 32'd0);
        check("rst_rxdr", 32'(uart_rxdr), 32'd0);
        check("rst_txen", 32'(fifo_txen), 32'd0);
        check("rst_txd",  32'(fifo_txd), 32'd0);
        check("rst_cnt",  32'(rx_cnt), 32'd0);
        check("rst_err",  32'(err), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("idle_rxdr", 32'(uart_rxdr), 32'd1);

        // 1. Normal frame of 12, data_len changed mid-frame must be ignored
        wr0 = wr_count;
        start_frame(8'd12);
        send_byte(8'h55, 1'b0);
        data_len = 8'd3;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(i), 1'b1);
            if (i == 10) check("t1_fd_early", 32'(fd), 32'd0);
        end
        check("t1_fd",     32'(fd), 32'd1);
        check("t1_txen",   32'(fifo_txen), 32'd1);
        check("t1_cnt",    32'(rx_cnt), 32'd12);
        check("t1_err",    32'(err), 32'd0);
        check("t1_rxdr",   32'(uart_rxdr), 32'd0);
        @(negedge clk);
        check("t1_fd_hold", 32'(fd), 32'd1);
        check("t1_writes", 32'(wr_count - wr0), 32'd12);
        fs = 1'b0;
        @(negedge clk);
        check("t1_fd_clear", 32'(fd), 32'd0);
        @(negedge clk);

        // 2. Header hunt
        wr0 = wr_count;
        start_frame(8'd2);
        send_byte(8'hAA, 1'b0);
        send_byte(8'h13, 1'b0);
        send_byte(8'h55, 1'b0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h02, 1'b1);
        check("t2_fd",     32'(fd), 32'd1);
        check("t2_cnt",    32'(rx_cnt), 32'd2);
        @(negedge clk);
        check("t2_writes", 32'(wr_count - wr0), 32'd2);
        end_frame();

        // 3. Back-pressure for 500 cycles with a byte held
        wr0 = wr_count;
        start_frame(8'd4);
        send_byte(8'h55, 1'b0);
        send_byte(8'hA0, 1'b1);
        send_byte(8'hA1, 1'b1);
        fifo_full = 1'b1;
        uart_rxd  = 8'hC3;
        uart_rxdv = 1'b1;
        rdy_seen  = 1'b0;
        err_seen  = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            #1;
            if (uart_rxdr !== 1'b0) rdy_seen = 1'b1;
            if (err !== 1'b0 || fd !== 1'b0) err_seen = 1'b1;
        end
        check("t3_rxdr_low",   32'(rdy_seen), 32'd0);
        check("t3_no_timeout", 32'(err_seen), 32'd0);
        check("t3_no_write",   32'(wr_count - wr0), 32'd2);
        @(negedge clk);
        fifo_full = 1'b0;
        send_byte(8'hC3, 1'b1);
        send_byte(8'hC4, 1'b1);
        check("t3_fd",     32'(fd), 32'd1);
        check("t3_cnt",    32'(rx_cnt), 32'd4);
        @(negedge clk);
        check("t3_writes", 32'(wr_count - wr0), 32'd4);
        end_frame();

        // 4. Inter-byte timeout
        start_frame(8'd5);
        send_byte(8'h55, 1'b0);
        send_byte(8'h31, 1'b1);
        send_byte(8'h32, 1'b1);
        send_byte(8'h33, 1'b1);
        n = 0;
        while (err !== 1'b1 && n < TIMEOUT_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        check("t4_err",     32'(err), 32'd1);
        check("t4_fd",      32'(fd), 32'd1);
        check("t4_latency", 32'(cyc - acc_edge + 1), 32'(TIMEOUT_CYC));
        check("t4_cnt",     32'(rx_cnt), 32'd3);
        fs = 1'b0;
        @(negedge clk);
        check("t4_fd_clear",  32'(fd), 32'd0);
        check("t4_err_clear", 32'(err), 32'd0);
        @(negedge clk);

        // 5. Abort after 2 of 4 bytes, then zero-length frame
        start_frame(8'd4);
        send_byte(8'h55, 1'b0);
        send_byte(8'h61, 1'b1);
        send_byte(8'h62, 1'b1);
        fs = 1'b0;
        err_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fd !== 1'b0 || err !== 1'b0) err_seen = 1'b1;
        end
        check("t5_no_fd",  32'(err_seen), 32'd0);
        check("t5_cnt",    32'(rx_cnt), 32'd2);
        wr0 = wr_count;
        data_len = 8'd0;
        fs = 1'b1;
        n = 0;
        while (fd !== 1'b1 && n < 2) begin
            @(negedge clk);
            n++;
        end
        check("t5_zero_fd",  32'(fd), 32'd1);
        check("t5_zero_cnt", 32'(rx_cnt), 32'd0);
        repeat (3) @(negedge clk);
        check("t5_zero_hold",   32'(fd), 32'd1);
        check("t5_zero_writes", 32'(wr_count - wr0), 32'd0);
        end_frame();

        // 6. Asynchronous reset mid-RECV
        start_frame(8'd8);
        send_byte(8'h55, 1'b0);
        send_byte(8'h7E, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_fd",   32'(fd), 32'd0);
        check("t6_txen", 32'(fifo_txen), 32'd0);
        check("t6_txd",  32'(fifo_txd), 32'd0);
        check("t6_cnt",  32'(rx_cnt), 32'd0);
        check("t6_rxdr", 32'(uart_rxdr), 32'd0);
        check("t6_err",  32'(err), 32'd0);
        fs        = 1'b0;
        uart_rxd  = 8'h5A;
        uart_rxdv = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wr0 = wr_count;
        repeat (10) @(negedge clk);
        check("t6_idle_writes", 32'(wr_count - wr0), 32'd0);
        check("t6_idle_fd",     32'(fd), 32'd0);
        check("t6_idle_rxdr",   32'(uart_rxdr), 32'd1);
        uart_rxdv = 1'b0;
        @(negedge clk);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
